// File: rtl/psum_deskew_drain_pkg.sv
// psum_deskew_drain_pkg: shared configuration, psum types, error bit indices and drain FSM states
package psum_deskew_drain_pkg;
  localparam int sys_cols = 2;
  localparam int P_BITWIDTH = 16;
  localparam int A_rows = 32;
  typedef logic signed [P_BITWIDTH-1:0] psum_t;
  typedef psum_t [sys_cols-1:0] psum_row_t;
  localparam int ERR_OVF = 0, ERR_SKEW = 1, ERR_UNEXP = 2;
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_e;
endpackage

// File: rtl/psum_deskew_drain_sync_fifo.sv
// sync_fifo: first-word fall-through FIFO with wrap-bit pointers; pushes while full are dropped
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic do_push, do_pop;
  assign full = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
  assign empty = wr_q == rd_q;
  assign count = wr_q - rd_q;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = empty ? '0 : mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + (AW+1)'(do_push);
      rd_q <= rd_q + (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
endmodule

// File: rtl/psum_deskew_drain.sv
// psum_deskew_drain: re-aligns skewed array column outputs into whole rows and streams them out of a FIFO
module psum_deskew_drain #(
  parameter int SYS_COLS   = psum_deskew_drain_pkg::sys_cols,
  parameter int P_BITWIDTH = psum_deskew_drain_pkg::P_BITWIDTH,
  parameter int DEPTH      = 16,
  parameter int MAX_ROWS   = psum_deskew_drain_pkg::A_rows
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           tile_start,
  input  logic [$clog2(MAX_ROWS+1)-1:0]  tile_rows,
  input  logic [SYS_COLS-1:0]            col_valid,
  input  logic [SYS_COLS*P_BITWIDTH-1:0] col_psum,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SYS_COLS*P_BITWIDTH-1:0] out_data,
  output logic                           out_last,
  output logic [$clog2(DEPTH):0]         free_slots,
  output logic                           busy,
  output logic                           tile_done,
  output logic [2:0]                     err_flags,
  input  logic                           err_clr
);
  import psum_deskew_drain_pkg::*;
  localparam int ROW_W = $clog2(MAX_ROWS+1);
  localparam int LW = SYS_COLS*P_BITWIDTH;
  localparam int CW = $clog2(DEPTH)+1;
  logic [SYS_COLS-1:0] av;
  logic [LW-1:0] ad;
  // Lane c waits SYS_COLS-1-c cycles so every lane lines up with the last column
  for (genvar c = 0; c < SYS_COLS; c++) begin : g_lane
    if (c == SYS_COLS-1) begin : g_direct
      assign av[c] = col_valid[c];
      assign ad[c*P_BITWIDTH +: P_BITWIDTH] = col_psum[c*P_BITWIDTH +: P_BITWIDTH];
    end else begin : g_dly
      localparam int N = SYS_COLS-1-c;
      logic [N-1:0] v_q;
      logic [N-1:0][P_BITWIDTH-1:0] d_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          v_q <= '0;
          d_q <= '0;
        end else begin
          v_q[0] <= col_valid[c];
          d_q[0] <= col_psum[c*P_BITWIDTH +: P_BITWIDTH];
          for (int s = 1; s < N; s++) begin
            v_q[s] <= v_q[s-1];
            d_q[s] <= d_q[s-1];
          end
        end
      assign av[c] = v_q[N-1];
      assign ad[c*P_BITWIDTH +: P_BITWIDTH] = d_q[N-1];
    end
  end
  state_e state_q;
  logic [ROW_W-1:0] rows_q, cnt_q;
  logic busy_q, done_q;
  logic [2:0] err_q, err_set;
  logic all_v, any_v, collect, push, last, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_cnt;
  assign all_v = &av;
  assign any_v = |av;
  assign collect = state_q == COLLECT;
  assign push = all_v && collect;
  assign last = cnt_q == rows_q - ROW_W'(1);
  always_comb begin
    err_set = '0;
    err_set[ERR_OVF] = push && fifo_full;
    err_set[ERR_SKEW] = any_v && !all_v;
    err_set[ERR_UNEXP] = all_v && !collect;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      rows_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (tile_start) begin
          rows_q <= tile_rows;
          cnt_q <= '0;
          busy_q <= 1'b1;
          state_q <= tile_rows == '0 ? DONE : COLLECT;
          done_q <= tile_rows == '0;
        end
        COLLECT: if (push) begin
          cnt_q <= cnt_q + ROW_W'(1);
          if (last) begin
            state_q <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= '0;
    else err_q <= (err_clr ? 3'b000 : err_q) | err_set;
  sync_fifo #(.WIDTH(LW+1), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .wdata({last, ad}),
    .pop(out_valid && out_ready), .rdata({out_last, out_data}),
    .full(fifo_full), .empty(fifo_empty), .count(fifo_cnt)
  );
  assign out_valid = !fifo_empty;
  assign free_slots = CW'(DEPTH) - fifo_cnt;
  assign busy = busy_q;
  assign tile_done = done_q;
  assign err_flags = err_q;
endmodule

// File: tb/tb_psum_deskew_drain.sv
// tb_psum_deskew_drain: directed vector tables plus multi-cycle corner sequences for psum_deskew_drain
module tb_psum_deskew_drain;
  logic clk = 0, rst_n = 0, tile_start = 0, out_ready = 0, err_clr = 0;
  logic [5:0] tile_rows = '0;
  logic [1:0] col_valid = '0;
  logic [31:0] col_psum = '0;
  logic out_valid, out_last, busy, tile_done;
  logic [31:0] out_data;
  logic [4:0] free_slots;
  logic [2:0] err_flags;
  int errors = 0, checks = 0, done_cnt = 0;
  logic [32:0] q[$];

  psum_deskew_drain dut (
    .clk(clk), .rst_n(rst_n), .tile_start(tile_start), .tile_rows(tile_rows),
    .col_valid(col_valid), .col_psum(col_psum), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .free_slots(free_slots), .busy(busy),
    .tile_done(tile_done), .err_flags(err_flags), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid && out_ready) q.push_back({out_last, out_data});
    if (tile_done) done_cnt++;
  end

  typedef struct {
    logic [1:0] v; logic [15:0] p0, p1;
    logic ev; logic [31:0] ed; logic el; logic [4:0] ef; logic eb, et;
  } vec_t;
  vec_t tbl[6];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_tbl();
    out_ready = 1; tile_rows = 6'd4; tile_start = 1;
    tick();
    tile_start = 0;
    for (int i = 0; i < 6; i++) begin
      col_valid = tbl[i].v; col_psum = {tbl[i].p1, tbl[i].p0};
      tick();
      chk($sformatf("t%0d.valid", i), out_valid, tbl[i].ev);
      chk($sformatf("t%0d.data", i), out_data, tbl[i].ed);
      chk($sformatf("t%0d.last", i), out_last, tbl[i].el);
      chk($sformatf("t%0d.free", i), free_slots, tbl[i].ef);
      chk($sformatf("t%0d.busy", i), busy, tbl[i].eb);
      chk($sformatf("t%0d.done", i), tile_done, tbl[i].et);
    end
    col_valid = '0; col_psum = '0;
  endtask

  function automatic logic [15:0] val(input int r, input int l);
    return 16'((r+1)*10 + l);
  endfunction

  task automatic feed(input int n);
    for (int k = 0; k <= n; k++) begin
      col_valid = {k >= 1, k < n};
      col_psum = {(k >= 1) ? val(k-1, 1) : 16'd0, (k < n) ? val(k, 0) : 16'd0};
      tick();
    end
    col_valid = '0; col_psum = '0;
  endtask

  initial begin
    int d0;
    tbl[0] = '{2'b01, 16'd10, 16'd0,  1'b0, 32'd0,                1'b0, 5'd16, 1'b1, 1'b0};
    tbl[1] = '{2'b11, 16'd20, 16'd11, 1'b1, {16'd11, 16'd10},     1'b0, 5'd15, 1'b1, 1'b0};
    tbl[2] = '{2'b11, 16'd30, 16'd21, 1'b1, {16'd21, 16'd20},     1'b0, 5'd15, 1'b1, 1'b0};
    tbl[3] = '{2'b11, 16'd40, 16'd31, 1'b1, {16'd31, 16'd30},     1'b0, 5'd15, 1'b1, 1'b0};
    tbl[4] = '{2'b10, 16'd0,  16'd41, 1'b1, {16'd41, 16'd40},     1'b1, 5'd15, 1'b1, 1'b1};
    tbl[5] = '{2'b00, 16'd0,  16'd0,  1'b0, 32'd0,                1'b0, 5'd16, 1'b0, 1'b0};
    #1;
    chk("rst.valid", out_valid, 0);
    chk("rst.free", free_slots, 16);
    chk("rst.busy", busy, 0);
    chk("rst.done", tile_done, 0);
    chk("rst.err", err_flags, 0);
    chk("rst.data", {out_last, out_data}, 0);
    tick(); tick();
    rst_n = 1;
    tick();

    run_tbl();
    tick();
    chk("t1.done_once", done_cnt, 1);
    chk("t1.err", err_flags, 0);

    out_ready = 0; tile_rows = 6'd20; tile_start = 1;
    tick();
    tile_start = 0;
    feed(20);
    tick(); tick();
    chk("t2.free0", free_slots, 0);
    chk("t2.ovf", err_flags, 3'b001);
    chk("t2.done", done_cnt, 2);
    chk("t2.busy", busy, 0);
    q.delete();
    out_ready = 1;
    for (int i = 0; i < 17; i++) tick();
    out_ready = 0;
    chk("t2.nrows", q.size(), 16);
    for (int i = 0; i < 16 && i < q.size(); i++)
      chk($sformatf("t2.row%0d", i), q[i], {1'b0, val(i, 1), val(i, 0)});
    chk("t2.free16", free_slots, 16);
    err_clr = 1; tick(); err_clr = 0;
    chk("t2.clr", err_flags, 0);

    col_valid = 2'b01; col_psum = 32'd5; tick();
    col_valid = 2'b00; col_psum = '0; tick();
    chk("t3.skew", err_flags, 3'b010);
    chk("t3.free", free_slots, 16);
    chk("t3.valid", out_valid, 0);
    err_clr = 1; tick(); err_clr = 0;
    chk("t3.clr", err_flags, 0);

    col_valid = 2'b01; col_psum = 32'd7; tick();
    col_valid = 2'b10; col_psum = {16'd8, 16'd0}; tick();
    col_valid = 2'b00; col_psum = '0;
    chk("t4.unexp", err_flags, 3'b100);
    chk("t4.free", free_slots, 16);
    chk("t4.valid", out_valid, 0);
    err_clr = 1; tick(); err_clr = 0;
    chk("t4.clr", err_flags, 0);
    col_valid = 2'b01; tick();
    col_valid = 2'b00; err_clr = 1; tick(); err_clr = 0;
    chk("t4.set_wins", err_flags, 3'b010);
    err_clr = 1; tick(); err_clr = 0;

    d0 = done_cnt;
    tile_rows = 6'd0; tile_start = 1; tick(); tile_start = 0;
    chk("t5.done", tile_done, 1);
    chk("t5.busy", busy, 1);
    tick();
    chk("t5.done_off", tile_done, 0);
    chk("t5.busy_off", busy, 0);
    chk("t5.count", done_cnt - d0, 1);
    chk("t5.valid", out_valid, 0);

    d0 = done_cnt;
    out_ready = 0; tile_rows = 6'd4; tile_start = 1; tick(); tile_start = 0;
    for (int k = 0; k < 3; k++) begin
      col_valid = {k >= 1, 1'b1};
      col_psum = {(k >= 1) ? val(k-1, 1) : 16'd0, val(k, 0)};
      tick();
    end
    col_valid = '0; col_psum = '0;
    chk("t6.pre_free", free_slots, 14);
    rst_n = 0; #2;
    chk("t6.valid", out_valid, 0);
    chk("t6.free", free_slots, 16);
    chk("t6.busy", busy, 0);
    tick();
    rst_n = 1;
    tick(); tick();
    chk("t6.no_done", done_cnt - d0, 0);
    chk("t6.err", err_flags, 0);
    run_tbl();
    tick();
    chk("t6.done_after", done_cnt - d0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
